// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter for a shared 32-bit word memory (IDLE -> ACCESS -> RESP).
// Optional macro MEM_ARB_ALIGN_CHECK_EN adds an err output and blocks misaligned/out-of-range access.
module mem_arbiter #(
  parameter int unsigned ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [31:0]       wdata0,
  input  logic [31:0]       wdata1,
  output logic              ack0,
  output logic              ack1,
  output logic [31:0]       rdata,
  output logic              busy,
  output logic              mem_write,
  output logic              mem_read,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wrdata,
`ifdef MEM_ARB_ALIGN_CHECK_EN
  output logic              err,
`endif
  input  logic [31:0]       mem_rddata
);

  typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

  state_e              state_q, state_d;
  logic                win_q;
  logic                rr_q;
  logic                we_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [31:0]         wdata_q;
  logic [31:0]         rdata_q;
  logic                any_req;
  logic                grant_sel;
  logic                addr_ok;

  assign any_req   = req0 | req1;
  // A lone requester always wins; the pointer only breaks ties.
  assign grant_sel = (req0 && req1) ? rr_q : req1;

`ifdef MEM_ARB_ALIGN_CHECK_EN
  assign addr_ok = (addr_q[1:0] == 2'b00) && (addr_q <= ADDR_W'(1020));
  assign err     = (state_q == StResp) && !addr_ok;
`else
  assign addr_ok = 1'b1;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:   if (any_req) state_d = StAccess;
      StAccess: state_d = StResp;
      StResp:   state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      win_q   <= 1'b0;
      rr_q    <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == StIdle && any_req) begin
        win_q   <= grant_sel;
        we_q    <= grant_sel ? we1 : we0;
        addr_q  <= grant_sel ? addr1 : addr0;
        wdata_q <= grant_sel ? wdata1 : wdata0;
      end
      if (state_q == StAccess && !we_q && addr_ok) rdata_q <= mem_rddata;
      if (state_q == StResp) rr_q <= ~win_q;
    end
  end

  // Strobes decode straight from state so an async reset kills them mid-cycle.
  assign mem_write  = (state_q == StAccess) && we_q && addr_ok;
  assign mem_read   = (state_q == StAccess) && !we_q && addr_ok;
  assign mem_addr   = addr_q;
  assign mem_wrdata = wdata_q;
  assign rdata      = rdata_q;
  assign busy       = (state_q != StIdle);
  assign ack0       = (state_q == StResp) && !win_q;
  assign ack1       = (state_q == StResp) && win_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: transaction-level model with a per-cycle compare, plus directed literal checks.
module tb_mem_arbiter;
  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        req0 = 0, req1 = 0, we0 = 0, we1 = 0;
  logic [9:0]  addr0 = '0, addr1 = '0;
  logic [31:0] wdata0 = '0, wdata1 = '0;
  logic        ack0, ack1, busy, mem_write, mem_read;
  logic [31:0] rdata, mem_wrdata, mem_rddata;
  logic [9:0]  mem_addr;
`ifdef MEM_ARB_ALIGN_CHECK_EN
  logic        err;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] mem    [256];
  logic [31:0] shadow [256];

  mem_arbiter #(.ADDR_W(10)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .ack0(ack0), .ack1(ack1), .rdata(rdata), .busy(busy),
    .mem_write(mem_write), .mem_read(mem_read),
    .mem_addr(mem_addr), .mem_wrdata(mem_wrdata),
`ifdef MEM_ARB_ALIGN_CHECK_EN
    .err(err),
`endif
    .mem_rddata(mem_rddata)
  );

  always #5 clk = ~clk;

  // Shared word memory seen by the DUT.
  assign mem_rddata = mem[mem_addr[9:2]];
  always @(posedge clk) if (mem_write) mem[mem_addr[9:2]] <= mem_wrdata;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  // ---------------- transaction-level model ----------------
  // One transaction in flight: age 0 = memory cycle, age 1 = response cycle.
  logic        m_active, m_age, m_rr, m_who, m_we;
  logic [9:0]  m_addr;
  logic [31:0] m_wdata, m_rdata;

  function automatic logic pick(input logic r0, input logic r1, input logic rr);
    if (r0 && r1) return rr;
    if (r0) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic legal(input logic [9:0] a);
`ifdef MEM_ARB_ALIGN_CHECK_EN
    return (int'(a) % 4 == 0) && (int'(a) <= 1020);
`else
    return (a === a);
`endif
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_active <= 0; m_age <= 0; m_rr <= 0; m_who <= 0; m_we <= 0;
      m_addr <= '0; m_wdata <= '0; m_rdata <= '0;
    end else if (m_active) begin
      if (!m_age) begin
        m_age <= 1;
        if (legal(m_addr)) begin
          if (m_we) shadow[int'(m_addr) / 4] <= m_wdata;
          else      m_rdata <= shadow[int'(m_addr) / 4];
        end
      end else begin
        m_active <= 0;
        m_rr     <= !m_who;
      end
    end else if (req0 || req1) begin
      m_active <= 1;
      m_age    <= 0;
      m_who    <= pick(req0, req1, m_rr);
      m_we     <= pick(req0, req1, m_rr) ? we1 : we0;
      m_addr   <= pick(req0, req1, m_rr) ? addr1 : addr0;
      m_wdata  <= pick(req0, req1, m_rr) ? wdata1 : wdata0;
    end
  end

  always @(negedge clk) begin
    logic mem_phase, rsp_phase;
    mem_phase = m_active && !m_age;
    rsp_phase = m_active && m_age;
    check("busy", 32'(busy), 32'(m_active));
    check("ack0", 32'(ack0), 32'(rsp_phase && !m_who));
    check("ack1", 32'(ack1), 32'(rsp_phase && m_who));
    check("mem_write", 32'(mem_write), 32'(mem_phase && m_we && legal(m_addr)));
    check("mem_read", 32'(mem_read), 32'(mem_phase && !m_we && legal(m_addr)));
    check("mem_addr", 32'(mem_addr), 32'(m_addr));
    check("mem_wrdata", mem_wrdata, m_wdata);
    check("rdata", rdata, m_rdata);
`ifdef MEM_ARB_ALIGN_CHECK_EN
    check("err", 32'(err), 32'(rsp_phase && !legal(m_addr)));
`endif
  end

  // ---------------- directed stimulus ----------------
  task automatic access(input logic port, input logic we, input logic [9:0] a,
                        input logic [31:0] wd, output int edges, output int wrc,
                        output int rdc, output logic [31:0] rd, output logic er);
    edges = 0; wrc = 0; rdc = 0; rd = '0; er = 0;
    if (port) begin req1 = 1; we1 = we; addr1 = a; wdata1 = wd; end
    else      begin req0 = 1; we0 = we; addr0 = a; wdata0 = wd; end
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      edges++;
      if (mem_write) wrc++;
      if (mem_read) rdc++;
      if (port ? ack1 : ack0) begin
        rd = rdata;
`ifdef MEM_ARB_ALIGN_CHECK_EN
        er = err;
`endif
        break;
      end
    end
    if (edges >= 8) check("ack_timeout", 32'(edges), 32'd2);
    req0 = 0; req1 = 0;
    @(posedge clk); #1;
  endtask

  int          e, wc, rc;
  logic [31:0] rd;
  logic        er;
  int          ack_who [4];
  int          ack_cyc [4];
  int          n_acks;

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem[i]    = 32'hC0DE_0000 | i;
      shadow[i] = 32'hC0DE_0000 | i;
    end
    #1 rst_n = 0;
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_rdata", rdata, 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_strobes", 32'({mem_write, mem_read, ack0, ack1}), 32'd0);
    @(negedge clk); rst_n = 1;
    @(posedge clk); #1;

    // Single write then read-back by the other port.
    access(1'b0, 1'b1, 10'h010, 32'hA1B2C3D4, e, wc, rc, rd, er);
    check("wr_ack_edges", 32'(e), 32'd2);
    check("wr_strobe_cycles", 32'(wc), 32'd1);
    check("wr_mem_word", mem[4], 32'hA1B2C3D4);
    access(1'b1, 1'b0, 10'h010, 32'h0, e, wc, rc, rd, er);
    check("rd_data", rd, 32'hA1B2C3D4);
    check("rd_no_write", 32'(wc), 32'd0);
    check("rd_ack_edges", 32'(e), 32'd2);
    access(1'b0, 1'b0, 10'h100, 32'h0, e, wc, rc, rd, er);
    check("rd_init_word", rd, 32'hC0DE0040);

    // Inputs changed during ACCESS must not disturb the latched request.
    req0 = 1; we0 = 1; addr0 = 10'h030; wdata0 = 32'h11112222;
    @(posedge clk); #1;
    addr0 = 10'h034; wdata0 = 32'h99999999;
    check("chg_mem_addr", 32'(mem_addr), 32'h030);
    @(posedge clk); #1;
    check("chg_ack0", 32'(ack0), 32'd1);
    req0 = 0;
    @(posedge clk); #1;
    check("chg_word_030", mem[12], 32'h11112222);
    check("chg_word_034", mem[13], 32'hC0DE000D);

    // Reset during the memory cycle of a write.
    req0 = 1; we0 = 1; addr0 = 10'h020; wdata0 = 32'hDEADBEEF;
    @(posedge clk); #1;
    check("rst_pre_write", 32'(mem_write), 32'd1);
    #2 rst_n = 0; req0 = 0;
    #1;
    check("rst_mid_write", 32'(mem_write), 32'd0);
    check("rst_mid_busy", 32'(busy), 32'd0);
    check("rst_mid_ack", 32'({ack0, ack1}), 32'd0);
    @(posedge clk); #1;
    @(negedge clk); rst_n = 1;
    @(posedge clk); #1;
    check("rst_word_020", mem[8], 32'hC0DE0008);

    // Tie right after reset: requester 0 first, then alternate.
    req0 = 1; we0 = 0; addr0 = 10'h010;
    req1 = 1; we1 = 0; addr1 = 10'h030;
    n_acks = 0;
    for (int i = 1; i <= 12; i++) begin
      @(posedge clk); #1;
      if ((ack0 || ack1) && n_acks < 4) begin
        ack_who[n_acks] = ack1 ? 1 : 0;
        ack_cyc[n_acks] = i;
        n_acks++;
      end
    end
    req0 = 0; req1 = 0;
    check("tie_ack_count", 32'(n_acks), 32'd4);
    for (int k = 0; k < 4; k++) begin
      if (k < n_acks) begin
        check("tie_order", 32'(ack_who[k]), 32'(k % 2));
        check("tie_cycle", 32'(ack_cyc[k]), 32'(2 + 3 * k));
      end
    end
    repeat (4) @(posedge clk);
    #1;

`ifdef MEM_ARB_ALIGN_CHECK_EN
    access(1'b1, 1'b0, 10'h100, 32'h0, e, wc, rc, rd, er);
    check("al_ref_read", rd, 32'hC0DE0040);
    access(1'b0, 1'b0, 10'h013, 32'h0, e, wc, rc, rd, er);
    check("al_013_err", 32'(er), 32'd1);
    check("al_013_strobes", 32'(wc + rc), 32'd0);
    check("al_013_rdata", rd, 32'hC0DE0040);
    access(1'b0, 1'b1, 10'h3FE, 32'h5A5A5A5A, e, wc, rc, rd, er);
    check("al_3fe_err", 32'(er), 32'd1);
    check("al_3fe_strobes", 32'(wc + rc), 32'd0);
    check("al_3fe_word", mem[255], 32'hC0DE00FF);
    access(1'b0, 1'b0, 10'h3FC, 32'h0, e, wc, rc, rd, er);
    check("al_3fc_ok", {31'd0, er}, 32'd0);
    check("al_3fc_data", rd, 32'hC0DE00FF);
`endif

    repeat (3) @(posedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required finish before 200000");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter: ADDR_W, 10, byte-address width; fixed to match the shared word memory.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have ports req0, req1  input  1 each  access request, level, held until matching ack.
REQ-005 SHALL have ports we0, we1  input  1 each  1 = write, 0 = read.
REQ-006 SHALL have ports addr0, addr1  input  ADDR_W each  byte address of 32-bit word access.
REQ-007 SHALL have ports wdata0, wdata1  input  32 each  write data, little-endian byte order.
REQ-008 SHALL have ports ack0, ack1  output  1 each  one-cycle completion pulse.
REQ-009 SHALL have port rdata  output  32  registered read data, shared, valid while ack0 or ack1 is high.
REQ-010 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-011 SHALL have ports mem_write, mem_read  output  1 each  memory strobes, never high together.
REQ-012 SHALL have ports mem_addr  output  ADDR_W; mem_wrdata  output  32; mem_rddata  input  32 (combinational from memory).

Function
REQ-013 SHALL implement an FSM with states IDLE, ACCESS and RESP.
REQ-014 IDLE: if any req is high at a rising edge, SHALL select a winner, latch its we/addr/wdata and go to ACCESS; otherwise it SHALL stay in IDLE.
REQ-015 Winner selection: with a single req, that requester SHALL win regardless of priority; with both high, the requester named by the round-robin pointer rr SHALL win.
REQ-016 ACCESS lasts exactly one cycle: mem_addr/mem_wrdata SHALL be driven from the latches, with mem_write=we or mem_read=!we.
REQ-017 At the edge ending ACCESS, a read SHALL capture mem_rddata into rdata, a write SHALL leave rdata unchanged, and the FSM SHALL go to RESP.
REQ-018 RESP lasts one cycle: ack of the winner SHALL be high, rr SHALL be set to the non-winner, and the FSM SHALL go to IDLE unconditionally.
REQ-019 Latency: req sampled at edge N SHALL produce ack high in cycle N+2..N+3; maximum throughput is one access per 3 cycles.
REQ-020 Requester inputs changing after the grant latch SHALL NOT affect the access in flight.
REQ-021 The requester SHALL drop req in the cycle after ack unless issuing a new request; req still high in IDLE SHALL be treated as a new request.
REQ-022 Outside ACCESS, mem_write and mem_read SHALL be 0, and mem_addr/mem_wrdata SHALL hold their last latched values.
REQ-023 ack0 and ack1 SHALL never be high simultaneously.

Reset
REQ-024 rst_n low SHALL immediately force state=IDLE, rr=0, ack0=ack1=0, busy=0, mem_write=mem_read=0, mem_addr=0, mem_wrdata=0, rdata=0.
REQ-025 Reset asserted during ACCESS SHALL deassert mem_write before the next clk edge, so no partial write occurs; the in-flight request SHALL be dropped without ack.
REQ-026 The first cycle after reset release SHALL behave as IDLE, with requester 0 preferred on a tie.

Configuration
REQ-027 Macro MEM_ARB_ALIGN_CHECK_EN SHALL control request checking.
REQ-028 With MEM_ARB_ALIGN_CHECK_EN defined, the block SHALL add output port err (1 bit, reset 0).
REQ-029 With MEM_ARB_ALIGN_CHECK_EN defined, a granted request with addr[1:0]!=0 or addr>1020 SHALL do the following in the ACCESS cycle: hold both strobes at 0, keep rdata unchanged, and pulse err together with ack in RESP.
REQ-030 Without MEM_ARB_ALIGN_CHECK_EN, the err port SHALL be absent and every address SHALL be passed to memory unchecked.

Verification
REQ-031 Single write: req0=1, we0=1, addr0=0x010, wdata0=0xA1B2C3D4 -> mem_write=1 for exactly one cycle with mem_addr=0x010, then ack0 two edges after sampling.
REQ-032 Read-back: req1=1, we1=0, addr1=0x010 after REQ-031 -> rdata=0xA1B2C3D4 during ack1, mem_write=0 throughout.
REQ-033 Tie after reset: req0=req1=1 held -> acks ordered ack0, ack1, ack0, ack1, each 3 cycles apart.
REQ-034 Reset mid-access: drop rst_n during ACCESS of a write to 0x020 -> mem_write=0 at once, no ack, word at 0x020 unchanged, busy=0.
REQ-035 Macro on: req0 with addr0=0x013, or with addr0=0x3FE -> no mem strobe, err=1 and ack0=1 in the same cycle, rdata unchanged.
REQ-036 Input change: modify addr0/wdata0 during ACCESS -> memory access uses the latched values.
